// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S serializer timed by an external mclk enable and a frame-rate pulse.
// A frame is 64 bit-clocks; each 32-bit half carries one sample MSB-first after a one-slot delay.
module i2s_tx #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mclk_ena,
  input  logic                    rate,
  input  logic signed [WIDTH-1:0] in_l,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sclk,
  output logic                    lrclk,
  output logic                    sdout,
  output logic                    frame,
  output logic                    underrun
);

  logic [7:0]              fcnt_q, fcnt_d;
  logic [63:0]             sr_q, sr_d;
  logic signed [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic signed [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic signed [WIDTH-1:0] load_l, load_r;
  logic                    hold_full_q, hold_full_d;
  logic                    frame_q, frame_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_start, accept;

  // One 32-bit I2S half-word: delay slot, sample MSB-first, zero padding.
  function automatic logic [31:0] pack_word(input logic signed [WIDTH-1:0] s);
    logic [31:0] w;
    w = '0;
    w[30 -: WIDTH] = s;
    return w;
  endfunction

  assign frame_start = rate | (mclk_ena & (fcnt_q == 8'd255));
  assign in_ready    = ~hold_full_q & ~reset;
  assign accept      = in_valid & in_ready;

  always_comb begin
    fcnt_d      = fcnt_q;
    sr_d        = sr_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    load_l      = last_l_q;
    load_r      = last_r_q;
    frame_d     = frame_start;
    underrun_d  = 1'b0;
    if (frame_start) begin
      fcnt_d = 8'd0;
      if (hold_full_q) begin
        load_l      = hold_l_q;
        load_r      = hold_r_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        // Sample arriving exactly at frame start bypasses the hold register.
        load_l = in_l;
        load_r = in_r;
      end else begin
        underrun_d = 1'b1;
      end
      sr_d     = {pack_word(load_l), pack_word(load_r)};
      last_l_d = load_l;
      last_r_d = load_r;
    end else begin
      if (mclk_ena) begin
        fcnt_d = fcnt_q + 8'd1;
        // Shift on the sclk falling edge so sdout is stable around the rising edge.
        if (fcnt_q[1:0] == 2'd3) sr_d = {sr_q[62:0], 1'b0};
      end
      if (accept) begin
        hold_l_d    = in_l;
        hold_r_d    = in_r;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q      <= '0;
      sr_q        <= '0;
      hold_full_q <= 1'b0;
      last_l_q    <= '0;
      last_r_q    <= '0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      sr_q        <= sr_d;
      hold_full_q <= hold_full_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  // Hold data is qualified by hold_full, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign sclk     = fcnt_q[1];
  assign lrclk    = fcnt_q[7];
  assign sdout    = sr_q[63];
  assign frame    = frame_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level reference model predicts every output each clock.
// Directed steps cover reset, the reference word pattern, hold/bypass/underrun and rate restart.
module tb_i2s_tx;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset, mclk_ena, rate, in_valid;
  logic signed [WIDTH-1:0] in_l, in_r;
  logic in_ready, sclk, lrclk, sdout, frame, underrun;

  i2s_tx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .mclk_ena(mclk_ena), .rate(rate),
    .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_ready(in_ready),
    .sclk(sclk), .lrclk(lrclk), .sdout(sdout), .frame(frame), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: position within frame (mclk count), words of the current frame,
  // last words sent, and a one-deep queue of accepted-but-unsent samples.
  int pos;
  logic [WIDTH-1:0] cur_l, cur_r, last_l, last_r;
  logic [2*WIDTH-1:0] pend[$];
  bit exp_frame, exp_underrun;

  int div, div_cnt;
  bit want_rate;
  int n_pass, n_fail, n_checks;
  int n_acc, n_frm, n_und;
  logic [63:0] sd_vec, lr_vec;

  function automatic bit slot_bit(input int s);
    int k;
    logic [WIDTH-1:0] w;
    k = s % 32;
    w = (s < 32) ? cur_l : cur_r;
    if (k >= 1 && k <= WIDTH) return w[WIDTH-k];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit fs, acc, exp_rdy;
    mclk_ena = (div_cnt == 0);
    div_cnt  = (div_cnt + 1) % div;
    rate     = want_rate && mclk_ena;
    if (rate) want_rate = 1'b0;
    #1;
    exp_rdy = !reset && (pend.size() == 0);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    #1;
    if (reset) begin
      pos = 0; cur_l = '0; cur_r = '0; last_l = '0; last_r = '0;
      pend.delete(); exp_frame = 1'b0; exp_underrun = 1'b0;
    end else begin
      fs = rate || (mclk_ena && pos == 255);
      exp_frame = fs;
      exp_underrun = 1'b0;
      if (fs) begin
        pos = 0;
        if (pend.size() > 0) {cur_l, cur_r} = pend.pop_front();
        else if (acc) begin cur_l = in_l; cur_r = in_r; end
        else begin cur_l = last_l; cur_r = last_r; exp_underrun = 1'b1; end
        last_l = cur_l; last_r = cur_r;
      end else begin
        if (mclk_ena) pos++;
        if (acc) pend.push_back({in_l, in_r});
      end
    end
    chk("sclk", 64'(sclk), 64'((pos / 2) % 2));
    chk("lrclk", 64'(lrclk), 64'(pos >= 128));
    chk("sdout", 64'(sdout), 64'(slot_bit(pos / 4)));
    chk("frame", 64'(frame), 64'(exp_frame));
    chk("underrun", 64'(underrun), 64'(exp_underrun));
    if (frame) n_frm++;
    if (underrun) n_und++;
  endtask

  task automatic wait_pos(input int p, input int lim);
    int k;
    k = 0;
    while (pos != p && k < lim) begin tick(); k++; end
    chk("wait_pos", 64'(pos == p), 64'd1);
  endtask

  // Runs until the DUT reports a frame, capturing sdout/lrclk per slot on the way.
  task automatic capture_frame(input string tag, input int lim);
    int k;
    k = 0;
    sd_vec = '0; lr_vec = '0;
    while (k < lim) begin
      tick(); k++;
      if (frame) break;
      if (pos % 4 == 1) begin
        sd_vec[63 - pos/4] = sdout;
        lr_vec[63 - pos/4] = lrclk;
      end
    end
    chk(tag, 64'(frame), 64'd1);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_checks = 0;
    pos = 0; cur_l = '0; cur_r = '0; last_l = '0; last_r = '0;
    exp_frame = 0; exp_underrun = 0;
    div = 4; div_cnt = 0; want_rate = 0;
    reset = 1'b1; rate = 1'b0; mclk_ena = 1'b0;
    in_valid = 1'b1; in_l = 16'sh1234; in_r = 16'sh4321;

    // Reset with offered data that must be ignored
    repeat (3) tick();
    in_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Reference pattern at div 4
    in_valid = 1'b1; in_l = 16'shA5C3; in_r = 16'sh8001;
    tick();
    in_valid = 1'b0;
    want_rate = 1'b1;
    capture_frame("rate_frame_seen", 20);
    capture_frame("wrap_frame_seen", 1100);
    chk("pattern_sdout", sd_vec, 64'h52E18000_40008000);
    chk("pattern_lrclk", lr_vec, 64'h00000000_FFFFFFFF);
    chk("underrun_on_wrap", 64'(underrun), 64'd1);
    capture_frame("repeat_frame_seen", 1100);
    chk("repeat_sdout", sd_vec, 64'h52E18000_40008000);

    // Free-running, valid held high: one accept per frame, no underrun
    div = 1; div_cnt = 0;
    n_acc = 0; n_frm = 0; n_und = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8 * 256; i++) begin
      in_l = WIDTH'($urandom); in_r = WIDTH'($urandom);
      tick();
    end
    chk("cont_frames", 64'(n_frm), 64'd8);
    chk("cont_accepts", 64'(n_acc), 64'd8);
    chk("cont_underruns", 64'(n_und), 64'd0);

    // Bypass: valid first appears in the frame_start cycle
    in_valid = 1'b0;
    wait_pos(255, 600);
    in_valid = 1'b1; in_l = WIDTH'($urandom); in_r = WIDTH'($urandom);
    tick();
    chk("bypass_frame", 64'(frame), 64'd1);
    chk("bypass_no_underrun", 64'(underrun), 64'd0);
    in_valid = 1'b0;
    #1;
    chk("bypass_ready", 64'(in_ready), 64'd1);

    // Valid withheld for a frame
    capture_frame("withheld_frame_seen", 300);
    chk("withheld_underrun", 64'(underrun), 64'd1);

    // Randomized traffic, rate pulses and occasional resets
    div = 2; div_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_l = WIDTH'($urandom); in_r = WIDTH'($urandom);
      if ($urandom_range(0, 399) == 0) want_rate = 1'b1;
      reset = ($urandom_range(0, 2999) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; want_rate = 1'b0;

    // Rate mid-frame, then reset mid-frame
    div = 1; div_cnt = 0;
    tick();
    wait_pos(100, 400);
    want_rate = 1'b1;
    tick();
    chk("rate_restart_frame", 64'(frame), 64'd1);
    chk("rate_restart_lrclk", 64'(lrclk), 64'd0);
    wait_pos(50, 400);
    reset = 1'b1;
    tick();
    chk("rst_outputs", 64'({sclk, lrclk, sdout, frame, underrun}), 64'd0);
    chk("rst_ready_low", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
